// File: rtl/image_scanout.sv
// Frame-snapshot reader: captures the flattened 8-bit image on start and streams its pixels
// in raster order over a valid/ready handshake, so a frame is never torn by source updates.
module image_scanout #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  parameter int XW     = 5,
  parameter int YW     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*HEIGHT*8-1:0] image,
  input  logic                      start,
  output logic                      busy,
  output logic [7:0]                pix_data,
  output logic [XW-1:0]             pix_x,
  output logic [YW-1:0]             pix_y,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_eol,
  output logic                      pix_eof,
  output logic [15:0]               frame_count
);

  // Handshake: a pixel transfers on every rising edge where pix_valid && pix_ready.
  // While pix_valid is high and pix_ready is low, all pix_* outputs hold; pix_valid only
  // falls after the final handshake of a frame (or on rst).

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_next;
  logic [7:0]      snap [N];
  logic            load, advance, finish;
  logic            hs, last_x, last_y;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic [IW-1:0]   next_idx;

  assign pix_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign hs        = pix_valid && pix_ready;
  assign last_x    = (pix_x == XW'(WIDTH - 1));
  assign last_y    = (pix_y == YW'(HEIGHT - 1));
  assign pix_eol   = pix_valid && last_x;
  assign pix_eof   = pix_eol && last_y;

  // Raster successor of the current pixel and its snapshot index.
  always_comb begin
    nx = '0;
    ny = pix_y;
    if (!last_x) nx = pix_x + 1'b1;
    else         ny = pix_y + 1'b1;
    next_idx = IW'(ny) * IW'(WIDTH) + IW'(nx);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (hs) begin
          if (last_x && last_y) begin
            finish = 1'b1;
            // A start on the closing handshake chains straight into the next frame.
            if (start) load = 1'b1;
            else       state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= 8'h00;
      frame_count <= 16'h0000;
      for (int i = 0; i < N; i++) snap[i] <= 8'h00;
    end else begin
      if (finish) frame_count <= frame_count + 16'd1;
      if (load) begin
        for (int i = 0; i < N; i++) snap[i] <= image[i*8 +: 8];
        pix_x    <= '0;
        pix_y    <= '0;
        pix_data <= image[7:0];
      end else if (advance) begin
        pix_x    <= nx;
        pix_y    <= ny;
        pix_data <= snap[next_idx];
      end else if (finish) begin
        pix_x <= '0;
        pix_y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_image_scanout.sv
// Bench for image_scanout: directed sequence with random image/ready stimulus, checked against
// a frame-level model that expands each captured image into its expected raster stream.
module tb_image_scanout;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int TW = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [W*H*8-1:0] image;
  logic             start;
  logic             busy;
  logic [7:0]       pix_data;
  logic [4:0]       pix_x;
  logic [4:0]       pix_y;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_eol;
  logic             pix_eof;
  logic [15:0]      frame_count;

  int checks = 0;
  int errors = 0;

  // Reference model: expected {data,x,y,eol,eof} stream, busy flag and completed frames.
  logic [TW-1:0] exp_q[$];
  logic          m_busy;
  logic [15:0]   m_fc;

  image_scanout #(.WIDTH(W), .HEIGHT(H), .XW(5), .YW(5)) dut (
    .clk(clk), .rst(rst), .image(image), .start(start), .busy(busy),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y, input logic [7:0] v);
    image[(y*W+x)*8 +: 8] = v;
  endtask

  task automatic rand_image();
    for (int i = 0; i < W*H; i++) image[i*8 +: 8] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_frame();
    logic [TW-1:0] e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e = {image[(y*W+x)*8 +: 8], 5'(x), 5'(y), (x == W-1), (x == W-1 && y == H-1)};
        exp_q.push_back(e);
      end
  endtask

  // One clock: check outputs against the model, apply start/ready, advance model and DUT.
  task automatic cycle(input logic s, input logic r);
    logic hs;
    start     = s;
    pix_ready = r;
    chk("pix_valid", 32'(pix_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_busy) chk("pixel", 32'({pix_data, pix_x, pix_y, pix_eol, pix_eof}), 32'(exp_q[0]));
    else        chk("eol_eof_idle", 32'({pix_eol, pix_eof}), 32'd0);
    hs = m_busy && r;
    if (hs) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_fc++;
        m_busy = 1'b0;
      end
    end
    if (s && !m_busy) begin
      push_frame();
      m_busy = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic drain(input bit rand_ready);
    for (int i = 0; i < 1000 && m_busy; i++)
      cycle(1'b0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    m_fc   = 16'd0;
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
  endtask

  initial begin
    image     = '0;
    start     = 1'b0;
    pix_ready = 1'b0;
    rst       = 1'b1;
    m_busy    = 1'b0;
    m_fc      = 16'd0;
    @(posedge clk);
    do_reset();
    cycle(1'b0, 1'b1);

    // Sparse image, full-rate streaming.
    set_pix(0, 0, 8'd12);
    set_pix(4, 4, 8'd255);
    cycle(1'b1, 1'b1);
    chk("lat1_valid", 32'(pix_valid), 32'd1);
    chk("lat1_data", 32'(pix_data), 32'd12);
    drain(1'b0);
    chk("frame1_fc", 32'(frame_count), 32'd1);

    // Random image under random backpressure.
    rand_image();
    cycle(1'b1, 1'($urandom_range(0, 1)));
    drain(1'b1);

    // Source changes after start must not reach the current frame.
    image = '0;
    set_pix(4, 4, 8'd255);
    cycle(1'b1, 1'b1);
    set_pix(4, 4, 8'd128);
    drain(1'b1);
    cycle(1'b1, 1'b1);
    drain(1'b0);

    // Start while busy at (3,2) is ignored and the snapshot is kept.
    rand_image();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 23; i++) cycle(1'b0, 1'b1);
    chk("at_3_2", 32'({pix_x, pix_y}), 32'({5'd3, 5'd2}));
    rand_image();
    cycle(1'b1, 1'b1);
    chk("after_3_2", 32'({pix_x, pix_y}), 32'({5'd4, 5'd2}));
    drain(1'b1);

    // Back-to-back frames with start held high.
    rand_image();
    for (int i = 0; i < 3*W*H; i++) begin
      if (i % 37 == 0) rand_image();
      cycle(1'b1, 1'b1);
    end
    chk("b2b_valid", 32'(pix_valid), 32'd1);
    drain(1'b0);

    // Reset mid-frame aborts with no count and no further pixels.
    rand_image();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    // Normal operation resumes after reset.
    rand_image();
    cycle(1'b1, 1'b1);
    drain(1'b1);
    cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
